// File: rtl/cell_list_writer.sv
// rtl/cell_list_writer.sv - scatters particles into per-cell lists and seals each list with a null sentinel
//
// Purpose:
//   Takes the particle stream from the cell-index stage and writes each
//   particle into the next free slot of its cell. Each cell has an
//   occupancy counter. At end of frame every cell that is not full gets a
//   null sentinel, so a downstream reader can tell where its list ends.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             one-cycle pulse; opens a frame and clears the counters
//   in_valid/in_ready particle handshake; in_last marks the final particle
//   in_cell[32:0]     [31:0] cell index, [32] null flag
//   in_pos[96:0]      [95:0] x,y,z fp32, [96] null flag
//   wr_en/wr_cell/wr_addr/wr_data   registered cell-memory write port
//   done              one-cycle pulse when sealing completes
//   overflow          sticky; a particle was dropped (cell full or index out of range)
//   drop_count        dropped particles since start, saturating
//   busy              high while running or sealing
module cell_list_writer #(
    parameter int NUM_CELLS  = 27,
    parameter int CELL_DEPTH = 64,
    parameter int AW         = 6,
    parameter int CW         = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [32:0]   in_cell,
    input  logic [96:0]   in_pos,
    output logic          wr_en,
    output logic [CW-1:0] wr_cell,
    output logic [AW-1:0] wr_addr,
    output logic [96:0]   wr_data,
    output logic          done,
    output logic          overflow,
    output logic [15:0]   drop_count,
    output logic          busy
);

    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(CELL_DEPTH);
    localparam logic [31:0]   NCELLS_C  = 32'(NUM_CELLS);
    localparam logic [CW-1:0] LAST_CELL = CW'(NUM_CELLS - 1);
    localparam logic [96:0]   SENTINEL  = {1'b1, 96'b0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SEAL = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Occupancy per cell; one extra bit so a full cell reads exactly CELL_DEPTH.
    logic [AW:0]   count [NUM_CELLS];
    logic [CW-1:0] seal_idx;

    logic          accept;
    logic          p_null;
    logic          p_range;
    logic          p_full;
    logic [CW-1:0] p_cell;
    logic [AW:0]   p_count;
    logic [AW:0]   s_count;
    logic          seal_last;

    assign accept    = in_valid & in_ready;
    assign p_null    = in_cell[32] | in_pos[96];
    assign p_range   = (in_cell[31:0] >= NCELLS_C);
    assign p_cell    = in_cell[CW-1:0];
    // Counts update on the handshake edge, so the next particle already sees
    // the incremented value: back-to-back hits to one cell need no extra forward.
    assign p_count   = count[p_cell];
    assign p_full    = (p_count == DEPTH_C);
    assign s_count   = count[seal_idx];
    assign seal_last = (seal_idx == LAST_CELL);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            // A start in the same cycle as in_last discards that particle and
            // keeps the frame open.
            RUN:  if (!start && accept && in_last) state_nxt = SEAL;
            SEAL: if (seal_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            SEAL: busy = 1'b1;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Datapath: counters, write port, drop accounting, seal walk
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                count[i] <= '0;
            end
            seal_idx   <= '0;
            wr_en      <= 1'b0;
            wr_cell    <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (state != SEAL) begin
                seal_idx <= '0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CELLS; i++) begin
                            count[i] <= '0;
                        end
                        overflow   <= 1'b0;
                        drop_count <= '0;
                    end
                end
                RUN: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CELLS; i++) begin
                            count[i] <= '0;
                        end
                        overflow   <= 1'b0;
                        drop_count <= '0;
                    end else if (accept && !p_null) begin
                        if (p_range || p_full) begin
                            overflow <= 1'b1;
                            if (drop_count != 16'hFFFF) begin
                                drop_count <= drop_count + 16'd1;
                            end
                        end else begin
                            wr_en          <= 1'b1;
                            wr_cell        <= p_cell;
                            wr_addr        <= p_count[AW-1:0];
                            wr_data        <= {1'b0, in_pos[95:0]};
                            count[p_cell]  <= p_count + 1'b1;
                        end
                    end
                end
                SEAL: begin
                    if (s_count != DEPTH_C) begin
                        wr_en   <= 1'b1;
                        wr_cell <= seal_idx;
                        wr_addr <= s_count[AW-1:0];
                        wr_data <= SENTINEL;
                    end
                    if (seal_last) begin
                        done <= 1'b1;
                    end
                    seal_idx <= seal_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_list_writer.sv
// tb/tb_cell_list_writer.sv - self-checking bench for cell_list_writer against a per-cell list model
module tb_cell_list_writer;

    localparam int NC  = 27;
    localparam int DEP = 64;
    localparam int AW  = 6;
    localparam int CW  = 5;
    localparam logic [96:0] SENT = {1'b1, 96'b0};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [32:0]   in_cell;
    logic [96:0]   in_pos;
    logic          wr_en;
    logic [CW-1:0] wr_cell;
    logic [AW-1:0] wr_addr;
    logic [96:0]   wr_data;
    logic          done;
    logic          overflow;
    logic [15:0]   drop_count;
    logic          busy;

    always #5 clk = ~clk;

    cell_list_writer #(.NUM_CELLS(NC), .CELL_DEPTH(DEP), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_cell(in_cell), .in_pos(in_pos),
        .wr_en(wr_en), .wr_cell(wr_cell), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .overflow(overflow), .drop_count(drop_count), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    // Reference model: one list per cell plus drop bookkeeping
    logic [96:0] m_mem [NC][DEP];
    int          m_cnt [NC];
    int          m_drop;
    bit          m_ovf;

    // What the DUT actually wrote this frame
    logic [96:0] cap_mem [NC][DEP];
    int          cap_n [NC];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = 0;
            cap_n[c] = 0;
            for (int s = 0; s < DEP; s++) begin
                m_mem[c][s]   = '0;
                cap_mem[c][s] = '0;
            end
        end
        m_drop   = 0;
        m_ovf    = 0;
        done_cnt = 0;
    endtask

    task automatic model_accept(input logic [32:0] c, input logic [96:0] p);
        if (c[32] || p[96]) begin
            // null padding: consumed silently
        end else if (c[31:0] >= NC || m_cnt[c[31:0]] == DEP) begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
        end else begin
            m_mem[c[31:0]][m_cnt[c[31:0]]] = p;
            m_cnt[c[31:0]]++;
        end
    endtask

    // Advance one clock; sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en && wr_cell < NC) begin
            cap_mem[wr_cell][wr_addr] = wr_data;
            cap_n[wr_cell]++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic drive(input bit v, input logic [32:0] c, input logic [96:0] p, input bit l);
        in_valid = v;
        in_cell  = c;
        in_pos   = p;
        in_last  = l;
    endtask

    task automatic push(input logic [32:0] c, input logic [96:0] p, input bit l);
        drive(1'b1, c, p, l);
        if (in_ready) model_accept(c, p);
        tick();
        drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    function automatic logic [96:0] rpos();
        return {1'b0, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [32:0] cidx(input int c);
        return {1'b0, 32'(c)};
    endfunction

    // Call right after the tick that accepted in_last. Checks seal timing and
    // then the whole frame against the model. kick_start probes start-in-SEAL.
    task automatic seal_and_check(input string tag, input bit kick_start);
        int  entry;
        bit  found;
        bit  ok;
        int  expn;
        entry = cyc;
        found = 0;
        check({tag, "_ready_low"}, in_ready, 1'b0);
        for (int k = 0; k < 40 && !found; k++) begin
            start = (kick_start && k == 5);
            tick();
            start = 1'b0;
            if (done) found = 1;
        end
        check({tag, "_done_seen"}, found, 1'b1);
        check({tag, "_done_lat"}, done_cyc - entry, 27);
        tick();
        tick();
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_idle"}, {busy, in_ready}, 2'b00);
        check({tag, "_ovf"}, overflow, m_ovf);
        check({tag, "_drops"}, drop_count, 16'(m_drop));
        for (int c = 0; c < NC; c++) begin
            ok = 1;
            for (int s = 0; s < m_cnt[c]; s++) begin
                if (cap_mem[c][s] !== m_mem[c][s]) ok = 0;
            end
            if (m_cnt[c] < DEP && cap_mem[c][m_cnt[c]] !== SENT) ok = 0;
            expn = m_cnt[c] + ((m_cnt[c] < DEP) ? 1 : 0);
            check($sformatf("%s_list%0d", tag, c), ok, 1'b1);
            check($sformatf("%s_nwr%0d", tag, c), cap_n[c], expn);
        end
    endtask

    initial begin
        logic [96:0] p;
        logic [32:0] c;
        int          r;

        rst   = 1'b1;
        start = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        model_clear();
        tick();
        tick();

        // Reset state
        check("rst_ready", in_ready, 1'b0);
        check("rst_wr", {wr_en, wr_cell, wr_addr, wr_data}, '0);
        check("rst_flags", {done, overflow, drop_count, busy}, '0);
        rst = 1'b0;
        tick();

        // Back-to-back scatter with a count forward on cell 4
        start_frame();
        check("run_busy", {busy, in_ready}, 2'b11);
        p = rpos(); push(cidx(4), p, 0);
        check("b2b_w0", {wr_en, wr_cell, wr_addr}, {1'b1, 5'd4, 6'd0});
        check("b2b_d0", wr_data, p);
        check("b2b_rdy", in_ready, 1'b1);
        p = rpos(); push(cidx(4), p, 0);
        check("b2b_w1", {wr_en, wr_cell, wr_addr}, {1'b1, 5'd4, 6'd1});
        p = rpos(); push(cidx(26), p, 0);
        check("b2b_w2", {wr_en, wr_cell, wr_addr}, {1'b1, 5'd26, 6'd0});
        p = rpos(); push(cidx(4), p, 1);
        check("b2b_w3", {wr_en, wr_cell, wr_addr}, {1'b1, 5'd4, 6'd2});
        check("b2b_d3", wr_data, p);
        seal_and_check("f1", 0);

        // Fill cell 0 and overflow it by one
        start_frame();
        for (int i = 0; i < DEP + 1; i++) push(cidx(0), rpos(), i == DEP);
        check("full_wen", wr_en, 1'b0);
        check("full_ovf", overflow, 1'b1);
        check("full_drop", drop_count, 16'd1);
        seal_and_check("f2", 0);

        // Out-of-range and null particles
        start_frame();
        push(cidx(27), rpos(), 0);
        check("rng_wen", wr_en, 1'b0);
        push({1'b1, 32'd3}, rpos(), 0);
        check("ncell_wen", wr_en, 1'b0);
        push(cidx(3), {1'b1, 96'h5}, 1);
        check("npos_wen", wr_en, 1'b0);
        check("null_ovf", overflow, 1'b1);
        check("null_drop", drop_count, 16'd1);
        seal_and_check("f3", 0);

        // Three particles in cell 2 only; start pulsed during SEAL is ignored
        start_frame();
        for (int i = 0; i < 3; i++) push(cidx(2), rpos(), i == 2);
        seal_and_check("f4", 1);

        // Random valid gaps and cell mix
        start_frame();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 99);
                if (r < 5)       c = cidx(27 + $urandom_range(0, 1000));
                else if (r < 10) c = {1'b1, 32'($urandom_range(0, 26))};
                else             c = cidx($urandom_range(0, 26));
                p = rpos();
                if ($urandom_range(0, 99) < 4) p[96] = 1'b1;
                push(c, p, 0);
            end else begin
                drive(1'b0, '0, '0, 1'b0);
                tick();
            end
        end
        push(cidx($urandom_range(0, 26)), rpos(), 1);
        seal_and_check("frnd", 0);

        // Reset mid-frame: in-flight particle not written, counters restart
        start_frame();
        for (int i = 0; i < 3; i++) push(cidx(5), rpos(), 0);
        drive(1'b1, cidx(5), rpos(), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        check("rstrun_wen", {wr_en, busy}, 2'b00);
        start_frame();
        p = rpos(); push(cidx(5), p, 0);
        check("rstrun_addr", {wr_en, wr_cell, wr_addr}, {1'b1, 5'd5, 6'd0});
        push(cidx(9), rpos(), 1);
        seal_and_check("f6", 0);

        // Start mid-frame: concurrent particle discarded, counters and drops cleared
        start_frame();
        push(cidx(30), rpos(), 0);
        push(cidx(7), rpos(), 0);
        push(cidx(7), rpos(), 0);
        drive(1'b1, cidx(7), rpos(), 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        model_clear();
        check("strun_wen", wr_en, 1'b0);
        check("strun_clr", {busy, overflow, drop_count}, {1'b1, 1'b0, 16'd0});
        p = rpos(); push(cidx(7), p, 0);
        check("strun_addr", {wr_en, wr_cell, wr_addr}, {1'b1, 5'd7, 6'd0});
        push(cidx(7), rpos(), 1);
        seal_and_check("f7", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cell_list_writer.md
Name: cell_list_writer

Overview:
- Consumes the per-particle stream produced by the position-update / cell-index stage: a 33-bit cell index word plus a 97-bit updated position word.
- Scatters each particle into the per-cell particle memory at the next free slot of its cell, keeping an occupancy counter per cell.
- At end of frame, seals every non-full cell with a null sentinel so downstream cell readers know where each list ends, then signals done.

Parameters:
- NUM_CELLS, 27, number of cells (3x3x3 index space, index 0..26)
- CELL_DEPTH, 64, particle slots per cell; power of two, at least 2
- AW, 6, slot address width (log2 CELL_DEPTH)
- CW, 5, cell-select width (ceil log2 NUM_CELLS)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame and clears all occupancy counters
- in_valid  in  1  particle word valid
- in_ready  out  1  particle word accepted when in_valid & in_ready
- in_last  in  1  marks the final particle of the frame; qualified by the handshake
- in_cell  in  33  [31:0] cell index, [32] null flag
- in_pos  in  97  [95:0] x,y,z fp32 (x in [31:0]), [96] null flag
- wr_en  out  1  cell memory write strobe
- wr_cell  out  CW  target cell
- wr_addr  out  AW  slot within the cell
- wr_data  out  97  word written to the slot
- done  out  1  one-cycle pulse when sealing completes
- overflow  out  1  sticky; a particle was dropped because its cell was full or its index was out of range
- drop_count  out  16  count of particles dropped since start; saturates at 0xFFFF
- busy  out  1  high in RUN and SEAL

Behaviour:
- Reset: state=IDLE; all counters=0; in_ready=0, wr_en=0, wr_cell=0, wr_addr=0, wr_data=0, done=0, overflow=0, drop_count=0, busy=0.

State machine IDLE/RUN/SEAL:
- IDLE:
  - in_ready=0.
  - start -> RUN; counters, overflow and drop_count are cleared in that same edge.
- RUN:
  - in_ready=1.
  - An accepted handshake with in_last=1 -> SEAL after that particle is processed.
  - start in RUN re-clears the counters and stays in RUN. A particle accepted in that same cycle is discarded and not counted.
- SEAL:
  - in_ready=0; iterates c=0..NUM_CELLS-1, one cell per cycle.
  - If count[c] < CELL_DEPTH: write wr_cell=c, wr_addr=count[c], wr_data={1'b1, 96'b0}. Counts are unchanged.
  - If the cell is full, no write that cycle.
  - After c=NUM_CELLS-1 -> IDLE with done=1 for exactly one cycle.
  - SEAL always takes NUM_CELLS cycles.
  - start is ignored in SEAL.

Per accepted particle in RUN:
- Null: in_cell[32] | in_pos[96]. The particle is consumed, nothing is written, drop_count does not change and overflow is not set. Null padding is legal.
- Range: in_cell[31:0] >= NUM_CELLS -> drop: overflow<=1, drop_count++ (saturating).
- Full: count[in_cell] == CELL_DEPTH -> drop, same as range.
- Otherwise:
  - Registered write on the next cycle: wr_en=1, wr_cell=in_cell[CW-1:0], wr_addr=count (pre-increment), wr_data=in_pos with bit 96 forced to 0.
  - count[in_cell] increments in the same edge that captures the write.

Timing and arithmetic:
- Latency is handshake to wr_en = 1 cycle. Throughput is 1 particle per cycle with no bubbles.
- Back-to-back particles to the same cell must get consecutive addresses; a count bypass or forward is required.
- Counters are AW+1 bits wide and never exceed CELL_DEPTH.
- wr_en is low whenever no write is issued.
- rst in any state returns to IDLE immediately; writes in flight are not issued.

Test Plan:
- Reset, then start. Send particles to cells 4, 4, 26, 4 with back-to-back valid -> writes (cell, addr) = (4,0), (4,1), (26,0), (4,2), each 1 cycle after its handshake; in_ready stays 1.
- Send 65 particles to cell 0 with CELL_DEPTH=64 -> addrs 0..63 written; the 65th is dropped, overflow=1, drop_count=1. In SEAL there is no write to cell 0.
- Send in_cell=27, then in_cell with bit32=1, then in_pos with bit96=1 -> no writes; overflow=1, drop_count=1.
- Frame with 3 particles in cell 2 only, last one with in_last=1 -> in_ready=0 from the next cycle. SEAL writes {1,0} at (c,0) for every c != 2 and at (2,3). done pulses exactly 27 cycles after SEAL entry, then IDLE.
- Toggle valid randomly with a final in_last, compare against a software model of per-cell lists -> memory contents match, each list is null-terminated, done pulses once.
- Assert rst mid-RUN, then start a new frame -> counters start at 0 and the first write to any cell lands at addr 0. Assert start mid-RUN -> same result.
